axi_matrix_key_scanner: RTL

Parametrised AXI4-Lite matrix-keypad controller, the successor to the fixed 4x4 key-board IP. It scans an ROWS x COLS switch matrix, debounces every key and records press/release events in a FIFO. It raises a level interrupt while events are pending. It sits behind the PS AXI interconnect as a 16-byte register slave, with `row_out`/`col_in` routed to package pins.

---
 rtl/axi_matrix_key_scanner.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_matrix_key_scanner.sv
// AXI4-Lite keypad scanner: row-by-row matrix scan, per-key debounce and a
// press/release event FIFO with a level interrupt.
module axi_matrix_key_scanner #(
  parameter int ROWS               = 4,
  parameter int COLS               = 4,
  parameter int SCAN_DIV           = 1000,
  parameter int DEBOUNCE           = 4,
  parameter int FIFO_DEPTH         = 8,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [ROWS-1:0]               row_out,
  input  logic [COLS-1:0]               col_in,
  output logic                          irq
);

  localparam int NKEYS = ROWS * COLS;
  localparam int KW    = $clog2(NKEYS);
  localparam int RW    = $clog2(ROWS);
  localparam int DW    = $clog2(SCAN_DIV);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  // state  | meaning
  // IDLE   | rows released, waiting for enable
  // SCAN   | row row_q driven low, columns sampled on its last cycle
  // UPDATE | one key per cycle through the debounce counters
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_UPDATE} state_t;

  state_t                    state_q, state_d;
  logic [RW-1:0]             row_q, row_d;
  logic [DW-1:0]             div_q, div_d;
  logic [KW-1:0]             key_q, key_d;
  logic [NKEYS-1:0]          raw_q, raw_d, deb_q, deb_d;
  logic [NKEYS-1:0][3:0]     cnt_q, cnt_d;
  logic [COLS-1:0]           col_meta_q, col_meta_d, col_sync_q, col_sync_d;
  logic                      enable_q, enable_d, irq_en_q, irq_en_d, ovf_q, ovf_d;
  logic [FIFO_DEPTH-1:0][8:0] mem_q, mem_d;
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic                      irq_q, irq_d;
  logic                      awready_q, awready_d, bvalid_q, bvalid_d;
  logic                      arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]               rdata_q, rdata_d;

  logic       ev_push, ev_press;
  logic       wr_hs, rd_hs, ctrl_wr, stat_wr, flush, pop, push_ok, empty, full;
  logic [31:0] rd_mux;
  logic       unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                       S_AXI_WSTRB, S_AXI_WDATA};

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    div_d      = div_q;
    key_d      = key_q;
    raw_d      = raw_q;
    deb_d      = deb_q;
    cnt_d      = cnt_q;
    ev_push    = 1'b0;
    ev_press   = 1'b0;
    col_meta_d = col_in;
    col_sync_d = col_meta_q;
    if (!enable_q) begin
      state_d = ST_IDLE;
      row_d   = '0;
      div_d   = '0;
      key_d   = '0;
      raw_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SCAN;
          row_d   = '0;
          div_d   = DW'(SCAN_DIV - 1);
        end
        ST_SCAN: begin
          if (div_q == '0) begin
            raw_d[row_q*COLS +: COLS] = ~col_sync_q;
            if (row_q == RW'(ROWS - 1)) begin
              state_d = ST_UPDATE;
              key_d   = '0;
            end else begin
              row_d = row_q + RW'(1);
              div_d = DW'(SCAN_DIV - 1);
            end
          end else begin
            div_d = div_q - DW'(1);
          end
        end
        ST_UPDATE: begin
          if (raw_q[key_q] == deb_q[key_q]) begin
            cnt_d[key_q] = 4'd0;
          end else if (cnt_q[key_q] == 4'(DEBOUNCE - 1)) begin
            deb_d[key_q] = raw_q[key_q];
            cnt_d[key_q] = 4'd0;
            ev_push      = 1'b1;
            ev_press     = raw_q[key_q];
          end else begin
            cnt_d[key_q] = cnt_q[key_q] + 4'd1;
          end
          if (key_q == KW'(NKEYS - 1)) begin
            state_d = ST_SCAN;
            row_d   = '0;
            div_d   = DW'(SCAN_DIV - 1);
          end else begin
            key_d = key_q + KW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    row_out = '1;
    if (state_q == ST_SCAN && enable_q) row_out[row_q] = 1'b0;
  end

  assign wr_hs   = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_hs   = arready_q & S_AXI_ARVALID;
  assign ctrl_wr = wr_hs & S_AXI_WSTRB[0] & (S_AXI_AWADDR[3:2] == 2'd0);
  assign stat_wr = wr_hs & S_AXI_WSTRB[0] & (S_AXI_AWADDR[3:2] == 2'd1);
  assign flush   = ctrl_wr & S_AXI_WDATA[2];
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = rd_hs & (S_AXI_ARADDR[3:2] == 2'd3) & ~empty;
  // A full FIFO still accepts an event if a pop frees a slot in the same cycle.
  assign push_ok = ev_push & (~full | pop);

  always_comb begin
    case (S_AXI_ARADDR[3:2])
      2'd0:    rd_mux = 32'({irq_en_q, enable_q});
      2'd1:    rd_mux = {17'b0, 7'(count_q), 5'b0, ovf_q, full, empty};
      2'd2:    rd_mux = 32'(deb_q);
      default: rd_mux = empty ? 32'h0 : {1'b1, 22'b0, mem_q[rd_ptr_q]};
    endcase
  end

  always_comb begin
    awready_d = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
    bvalid_d  = bvalid_q;
    arready_d = S_AXI_ARVALID & ~rvalid_q & ~arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    enable_d  = enable_q;
    irq_en_d  = irq_en_q;
    ovf_d     = ovf_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    irq_d     = irq_en_q & ~empty;
    if (wr_hs)              bvalid_d = 1'b1;
    else if (S_AXI_BREADY)  bvalid_d = 1'b0;
    if (rd_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
    if (ctrl_wr) begin
      enable_d = S_AXI_WDATA[0];
      irq_en_d = S_AXI_WDATA[1];
    end
    if (stat_wr && S_AXI_WDATA[2]) ovf_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (ev_push && full && !pop) ovf_d = 1'b1;
      if (push_ok) begin
        mem_d[wr_ptr_q] = {ev_press, 8'(key_q)};
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      div_q      <= '0;
      key_q      <= '0;
      raw_q      <= '0;
      deb_q      <= '0;
      cnt_q      <= '0;
      col_meta_q <= '0;
      col_sync_q <= '0;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      irq_q      <= 1'b0;
      awready_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      div_q      <= div_d;
      key_q      <= key_d;
      raw_q      <= raw_d;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      col_meta_q <= col_meta_d;
      col_sync_q <= col_sync_d;
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      ovf_q      <= ovf_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      irq_q      <= irq_d;
      awready_q  <= awready_d;
      bvalid_q   <= bvalid_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign irq           = irq_q;

endmodule
